// File: rtl/io_port_sequencer.sv
// io_port_sequencer
//   Runs Z80-style I/O cycles (T1/T2/TW/T3) against a 256-entry port bank
//   shared by two requesters: 0 = CPU core, 1 = debug/DMA engine.
//   Round-robin arbitration happens in IDLE only. Programmable and external
//   wait states are added in TW. A cycle that waits too long is aborted with
//   req_err set.
//
// Ports
//   clk, rst          clock, async active-high reset
//   req_valid/we      per-requester request, direction (1 = write)
//   req_addr/wdata    per-requester port number and write data
//   req_done/req_err  one-cycle completion pulse (per requester), abort flag
//   rdata             read result, valid while req_done is high
//   busy, grant       cycle in flight (T1..DONE), owner of the current cycle
//   wait_L            external wait, active low, sampled in T2/TW
//   IORQ_L/RD_L/WR_L  active-low strobes to the port bank
//   addr_bus          {8'h00, port}
//   data_out/data_in  write data to the bank, read data from the bank
module io_port_sequencer #(
  parameter int WAIT_STATES = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [1:0]      req_we,
  input  logic [1:0][7:0] req_addr,
  input  logic [1:0][7:0] req_wdata,
  output logic [1:0]      req_done,
  output logic            req_err,
  output logic [7:0]      rdata,
  output logic            busy,
  output logic            grant,
  input  logic            wait_L,
  output logic            IORQ_L,
  output logic            RD_L,
  output logic            WR_L,
  output logic [15:0]     addr_bus,
  output logic [7:0]      data_out,
  input  logic [7:0]      data_in
);

  // Counter is wide enough to reach TIMEOUT, so it cannot wrap first.
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] WS_C = CW'(WAIT_STATES);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wcnt, wcnt_inc;
  logic          rr_last;   // requester granted most recently
  logic          cur_we;
  logic          gnt_nx;
  logic          abort_nx;
  logic          strobe_nx;

  always_comb begin
    state_nx = state;
    gnt_nx   = grant;
    abort_nx = 1'b0;
    wcnt_inc = wcnt + CW'(1);
    case (state)
      S_IDLE: begin
        if (|req_valid) begin
          state_nx = S_T1;
          // On a tie the requester not served last wins; otherwise the
          // only valid one does.
          gnt_nx = (&req_valid) ? ~rr_last : req_valid[1];
        end
      end
      S_T1: state_nx = S_T2;
      S_T2: state_nx = ((WS_C != '0) || !wait_L) ? S_TW : S_T3;
      S_TW: begin
        // wcnt_inc is the number of TW cycles including this one.
        if ((wcnt_inc < WS_C) || !wait_L) begin
          if (wcnt_inc >= TO_C) begin
            state_nx = S_DONE;
            abort_nx = 1'b1;
          end
        end else begin
          state_nx = S_T3;
        end
      end
      S_T3:    state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Strobes are low for exactly the cycles spent in T2 and TW.
  assign strobe_nx = (state_nx == S_T2) || (state_nx == S_TW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= '0;
      rr_last  <= 1'b1;
      cur_we   <= 1'b0;
      grant    <= 1'b0;
      IORQ_L   <= 1'b1;
      RD_L     <= 1'b1;
      WR_L     <= 1'b1;
      addr_bus <= 16'h0000;
      data_out <= 8'h00;
      rdata    <= 8'h00;
      req_done <= 2'b00;
      req_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_nx;

      // Request fields are captured once; the bus then holds them T1..T3,
      // so a requester dropping valid mid-cycle has no effect.
      if (state == S_IDLE && state_nx == S_T1) begin
        grant    <= gnt_nx;
        cur_we   <= req_we[gnt_nx];
        addr_bus <= {8'h00, req_addr[gnt_nx]};
        if (req_we[gnt_nx]) data_out <= req_wdata[gnt_nx];
      end

      if (state == S_T2)      wcnt <= '0;
      else if (state == S_TW) wcnt <= wcnt_inc;

      IORQ_L <= ~strobe_nx;
      RD_L   <= ~(strobe_nx && !cur_we);
      WR_L   <= ~(strobe_nx && cur_we);
      busy   <= (state_nx != S_IDLE);

      req_done <= 2'b00;
      req_err  <= 1'b0;
      if (state_nx == S_DONE) begin
        req_done[grant] <= 1'b1;
        req_err         <= abort_nx;
        rdata           <= (abort_nx || cur_we) ? 8'h00 : data_in;
      end

      if (state == S_DONE) rr_last <= grant;
    end
  end

endmodule

// File: tb/tb_io_port_sequencer.sv
module tb_io_port_sequencer;
  localparam int WS = 1;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid, req_we;
  logic [1:0][7:0] req_addr, req_wdata;
  logic [1:0]      req_done;
  logic            req_err;
  logic [7:0]      rdata;
  logic            busy, grant;
  logic            wait_L;
  logic            IORQ_L, RD_L, WR_L;
  logic [15:0]     addr_bus;
  logic [7:0]      data_out, data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_port_sequencer #(.WAIT_STATES(WS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_done(req_done),
    .req_err(req_err), .rdata(rdata), .busy(busy), .grant(grant),
    .wait_L(wait_L), .IORQ_L(IORQ_L), .RD_L(RD_L), .WR_L(WR_L),
    .addr_bus(addr_bus), .data_out(data_out), .data_in(data_in)
  );

  // Port bank: each port resets to its own number; read data appears one
  // clock after IORQ_L&RD_L are seen low; writes land while IORQ_L&WR_L low.
  logic [7:0] bank [256];
  int low_cnt;   // cycles IORQ_L has been low in the current assertion
  int nw;        // bank holds wait_L low for the first nw strobe-low cycles

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) bank[i] <= 8'(i);
      data_in <= 8'h00;
      low_cnt <= 0;
    end else begin
      if (!IORQ_L && !RD_L) data_in <= bank[addr_bus[7:0]];
      if (!IORQ_L && !WR_L) bank[addr_bus[7:0]] <= data_out;
      low_cnt <= IORQ_L ? 0 : low_cnt + 1;
    end
  end

  assign wait_L = !(!IORQ_L && (low_cnt < nw));

  // Reference model
  logic [7:0] ref_mem [256];
  logic       rr_last;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
    rr_last = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from a lone requester; called with the DUT idle, just
  // after a rising edge.
  task automatic run_txn(input int r, input bit we, input logic [7:0] addr,
                         input logic [7:0] wd, input int nwait, input bit drop);
    int tw, lat, cyc, lows, rdl, wrl;
    bit abort, done;
    logic [7:0] exp_rd;
    abort  = (nwait > TO);
    tw     = abort ? TO : ((nwait > WS) ? nwait : WS);
    lat    = abort ? 3 + TO : 4 + tw;
    exp_rd = abort ? 8'h00 : ref_mem[addr];
    if (we) ref_mem[addr] = wd;   // bank sees WR_L low even if later aborted

    nw = nwait;
    req_we[r] = we; req_addr[r] = addr; req_wdata[r] = wd; req_valid[r] = 1'b1;
    cyc = 0; lows = 0; rdl = 0; wrl = 0; done = 0;
    while (cyc < 60 && !done) begin
      @(posedge clk); #1;
      cyc++;
      if (!IORQ_L) lows++;
      if (!RD_L) rdl++;
      if (!WR_L) wrl++;
      if (req_done != 2'b00) done = 1;
      if (drop && cyc == 2) req_valid[r] = 1'b0;
    end
    chk("done_seen", 32'(done), 1);
    chk("latency", cyc, lat);
    chk("done_bit", 32'(req_done), 32'(1 << r));
    chk("grant", 32'(grant), r);
    chk("err", 32'(req_err), 32'(abort));
    chk("iorq_low_cycles", lows, 1 + tw);
    chk("rd_low_cycles", rdl, we ? 0 : 1 + tw);
    chk("wr_low_cycles", wrl, we ? 1 + tw : 0);
    if (!we || abort) chk("rdata", 32'(rdata), 32'(exp_rd));
    req_valid[r] = 1'b0;
    rr_last = r[0];
    nw = 0;
    @(posedge clk); #1;
    chk("done_clear", 32'(req_done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  // Both requesters held valid with reads: grants must alternate.
  task automatic contention(input int n);
    logic w;
    int cyc;
    req_we = 2'b00;
    req_addr[0] = 8'h21; req_addr[1] = 8'h84;
    req_valid = 2'b11;
    w = ~rr_last;
    for (int k = 0; k < n; k++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (cyc < 30 && req_done == 2'b00);
      chk("cont_latency", cyc, (k == 0) ? 4 + WS : 5 + WS);
      chk("cont_done_bit", 32'(req_done), 32'(1 << w));
      chk("cont_grant", 32'(grant), 32'(w));
      chk("cont_rdata", 32'(rdata), 32'(ref_mem[req_addr[w]]));
      rr_last = w;
      w = ~w;
    end
    req_valid = 2'b00;
    @(posedge clk); #1;
  endtask

  initial begin
    int r, nwait;
    bit we, drop;
    logic [7:0] a, d;
    int dones;

    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; nw = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_iorq", 32'(IORQ_L), 1);
    chk("rst_rd", 32'(RD_L), 1);
    chk("rst_wr", 32'(WR_L), 1);
    chk("rst_addr", 32'(addr_bus), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_txn(0, 1'b0, 8'h5A, 8'h00, 0, 1'b0);   // single read of default value
    run_txn(1, 1'b1, 8'h10, 8'hC3, 0, 1'b0);   // write
    run_txn(1, 1'b0, 8'h10, 8'h00, 0, 1'b0);   // read back
    run_txn(0, 1'b0, 8'h10, 8'h00, 4, 1'b0);   // external wait: 3 extra TW
    run_txn(0, 1'b0, 8'h33, 8'h00, 255, 1'b0); // timeout abort
    run_txn(0, 1'b0, 8'h34, 8'h00, 0, 1'b0);   // recovers normally
    run_txn(1, 1'b0, 8'h10, 8'h00, 0, 1'b1);   // valid dropped mid-cycle
    contention(4);

    // Randomized traffic
    for (int k = 0; k < 30; k++) begin
      r     = int'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      a     = 8'($urandom_range(0, 15));
      d     = 8'($urandom);
      nwait = ($urandom_range(0, 5) == 0) ? 20 : int'($urandom_range(0, 6));
      drop  = ($urandom_range(0, 3) == 0);
      run_txn(r, we, a, d, nwait, drop);
    end
    contention(3);

    // Reset while stuck in TW
    nw = 255;
    req_we[0] = 1'b0; req_addr[0] = 8'h44; req_valid[0] = 1'b1;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_iorq", 32'(IORQ_L), 1);
    chk("arst_rd", 32'(RD_L), 1);
    chk("arst_wr", 32'(WR_L), 1);
    chk("arst_busy", 32'(busy), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b00; nw = 0;
    dones = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (req_done != 2'b00) dones++;
    end
    chk("arst_no_done", dones, 0);
    contention(2);   // pointer back to favouring requester 0
    run_txn(1, 1'b0, 8'h44, 8'h00, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
